// File: rtl/trace_capture_ctrl_pkg.sv
// Shared types and helpers for the trace capture controller.
package trace_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } cap_state_t;

    function automatic int tb_addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/trace_capture_ctrl_if.sv
// Compressor output stream and trace-buffer write port of the capture controller.
interface trace_capture_ctrl_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 6
);
    logic                           c_valid;
    logic [N-1:0][DATA_WIDTH-1:0]   c_vector;
    logic                           c_comp;
    logic                           c_inc_ptr;
    logic                           tb_we;
    logic [AW-1:0]                  tb_waddr;
    logic [N-1:0][DATA_WIDTH-1:0]   tb_wdata;
    logic                           tb_wcomp;

    modport master (
        output c_valid, c_vector, c_comp, c_inc_ptr,
        input  tb_we, tb_waddr, tb_wdata, tb_wcomp
    );

    modport slave (
        input  c_valid, c_vector, c_comp, c_inc_ptr,
        output tb_we, tb_waddr, tb_wdata, tb_wcomp
    );
endinterface

// File: rtl/trace_capture_ctrl_addr_gen.sv
// Trace-buffer write pointer: all-ones start, increment/wrap, sticky wrapped flag, last_addr.
// With TRACE_STOP_ON_FULL_EN a wrapping increment is refused and only marks the buffer full.
module tb_addr_gen
    import trace_ctrl_pkg::*;
#(
    parameter  int TB_DEPTH = 64,
    localparam int AW       = tb_addr_w(TB_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    input  logic          we,
    output logic [AW-1:0] waddr_s,
    output logic          inc_eff_s,
    output logic          wrap_s,
    output logic [AW-1:0] last_addr,
    output logic          wrapped
);
    logic [AW-1:0] ptr_r;
    logic [AW-1:0] last_addr_r;
    logic          empty_r;
    logic          wrapped_r;

    // Before the first entry of a session a rewrite has no slot, so it must allocate one.
    assign inc_eff_s = inc | empty_r;
    assign waddr_s   = inc_eff_s ? (ptr_r + AW'(1)) : ptr_r;
    assign wrap_s    = inc & ~empty_r & (ptr_r == {AW{1'b1}});
    assign last_addr = last_addr_r;
    assign wrapped   = wrapped_r;

    // Pointer, newest-entry address and wrap history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= {AW{1'b1}};
            last_addr_r <= {AW{1'b0}};
            empty_r     <= 1'b1;
            wrapped_r   <= 1'b0;
        end else if (clear) begin
            ptr_r     <= {AW{1'b1}};
            empty_r   <= 1'b1;
            wrapped_r <= 1'b0;
        end else if (we) begin
`ifdef TRACE_STOP_ON_FULL_EN
            if (wrap_s) begin
                wrapped_r <= 1'b1;
            end else begin
                ptr_r       <= waddr_s;
                last_addr_r <= waddr_s;
                empty_r     <= 1'b0;
            end
`else
            ptr_r       <= waddr_s;
            last_addr_r <= waddr_s;
            empty_r     <= 1'b0;
            if (wrap_s) begin
                wrapped_r <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: rtl/trace_capture_ctrl.sv
// Capture session sequencer: FSM, post-trigger countdown and registered trace-buffer writes.
// Optional one-shot mode (no overwrite once full) under macro TRACE_STOP_ON_FULL_EN.
module trace_capture_ctrl
    import trace_ctrl_pkg::*;
#(
    parameter  int N          = 8,
    parameter  int DATA_WIDTH = 32,
    parameter  int TB_DEPTH   = 64,
    parameter  int CNT_W      = 16,
    localparam int AW         = tb_addr_w(TB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 trigger,
    input  logic [CNT_W-1:0]     post_trig_cnt,
    output logic                 tracing,
    trace_capture_ctrl_if.slave  bus,
    output logic                 done,
    output logic [AW-1:0]        last_addr,
    output logic                 wrapped
);
`ifdef TRACE_STOP_ON_FULL_EN
    localparam logic STOP_ON_FULL = 1'b1;
`else
    localparam logic STOP_ON_FULL = 1'b0;
`endif

    cap_state_t                   state_r, state_s;
    logic [CNT_W-1:0]             cnt_r, cnt_s;
    logic                         accept_s, full_s, drop_s;
    logic [AW-1:0]                waddr_s;
    logic                         inc_eff_s, wrap_s;
    logic                         tracing_r, done_r, tb_we_r, tb_wcomp_r;
    logic [AW-1:0]                tb_waddr_r;
    logic [N-1:0][DATA_WIDTH-1:0] tb_wdata_r;

    tb_addr_gen #(.TB_DEPTH(TB_DEPTH)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (arm),
        .inc       (bus.c_inc_ptr),
        .we        (accept_s),
        .waddr_s   (waddr_s),
        .inc_eff_s (inc_eff_s),
        .wrap_s    (wrap_s),
        .last_addr (last_addr),
        .wrapped   (wrapped)
    );

    assign full_s = STOP_ON_FULL & wrap_s;
    assign drop_s = accept_s & full_s;

    // Next-state and post-trigger countdown; arm overrides everything else.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        if (arm) begin
            state_s = ARMED;
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: state_s = IDLE;
                ARMED: begin
                    accept_s = bus.c_valid;
                    if (bus.c_valid && full_s) begin
                        state_s = DONE;
                    end else if (trigger) begin
                        cnt_s   = post_trig_cnt;
                        state_s = (post_trig_cnt == {CNT_W{1'b0}}) ? DONE : POST;
                    end else begin
                        state_s = ARMED;
                    end
                end
                POST: begin
                    accept_s = bus.c_valid;
                    if (bus.c_valid && full_s) begin
                        state_s = DONE;
                    end else if (bus.c_valid && inc_eff_s) begin
                        cnt_s   = cnt_r - CNT_W'(1);
                        state_s = (cnt_r == CNT_W'(1)) ? DONE : POST;
                    end else begin
                        state_s = POST;
                    end
                end
                DONE:    state_s = DONE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered status and trace-buffer write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tracing_r  <= 1'b0;
            done_r     <= 1'b0;
            tb_we_r    <= 1'b0;
            tb_waddr_r <= {AW{1'b0}};
            tb_wdata_r <= {(N*DATA_WIDTH){1'b0}};
            tb_wcomp_r <= 1'b0;
        end else begin
            tracing_r <= arm | (state_r == ARMED) | (state_r == POST);
            done_r    <= ~arm & (state_r == DONE);
            tb_we_r   <= accept_s & ~drop_s;
            if (accept_s && !drop_s) begin
                tb_waddr_r <= waddr_s;
                tb_wdata_r <= bus.c_vector;
                tb_wcomp_r <= bus.c_comp;
            end
        end
    end

    assign tracing      = tracing_r;
    assign done         = done_r;
    assign bus.tb_we    = tb_we_r;
    assign bus.tb_waddr = tb_waddr_r;
    assign bus.tb_wdata = tb_wdata_r;
    assign bus.tb_wcomp = tb_wcomp_r;
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed scoreboard bench for trace_capture_ctrl with a 4-entry buffer.
module tb_trace_capture_ctrl;
    import trace_ctrl_pkg::*;

    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int AW    = tb_addr_w(DEPTH);
    localparam int VW    = N * DW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [VW-1:0] data;
        logic          comp;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             arm = 1'b0;
    logic             trigger = 1'b0;
    logic [CNT_W-1:0] post_trig_cnt = '0;
    logic             tracing, done, wrapped;
    logic [AW-1:0]    last_addr;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    trace_capture_ctrl_if #(.N(N), .DATA_WIDTH(DW), .AW(AW)) bus ();

    trace_capture_ctrl #(.N(N), .DATA_WIDTH(DW), .TB_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arm           (arm),
        .trigger       (trigger),
        .post_trig_cnt (post_trig_cnt),
        .tracing       (tracing),
        .bus           (bus.slave),
        .done          (done),
        .last_addr     (last_addr),
        .wrapped       (wrapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.c_valid   = 1'b0;
        bus.c_inc_ptr = 1'b0;
        bus.c_comp    = 1'b0;
    endtask

    // One compressor beat; acc says whether a buffer write at addr is expected.
    task automatic send(input logic inc, input logic comp, input logic acc, input logic [AW-1:0] addr);
        logic [VW-1:0] v;
        exp_t          e;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom();
        bus.c_valid   = 1'b1;
        bus.c_inc_ptr = inc;
        bus.c_comp    = comp;
        bus.c_vector  = v;
        if (acc) begin
            e = '{addr: addr, data: v, comp: comp};
            sb.push_back(e);
        end
        tick();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Scoreboard side: every buffer write must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.tb_we === 1'b1) begin
            chk("write_expected", VW'(sb.size() != 0), VW'(1));
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("tb_waddr", VW'(bus.tb_waddr), VW'(mon_e.addr));
                chk("tb_wdata", VW'(bus.tb_wdata), mon_e.data);
                chk("tb_wcomp", VW'(bus.tb_wcomp), VW'(mon_e.comp));
                chk("last_addr_with_we", VW'(last_addr), VW'(mon_e.addr));
            end
        end
    end

    initial begin
        idle();
        bus.c_vector = '0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_tracing", VW'(tracing), '0);
        chk("rst_done", VW'(done), '0);
        chk("rst_wrapped", VW'(wrapped), '0);
        chk("rst_last_addr", VW'(last_addr), '0);
        chk("rst_tb_we", VW'(bus.tb_we), '0);
        rst_n = 1'b1;
        tick();

        // inc=1,0,0,0,1 -> 0,0,0,0,1
        pulse_arm();
        chk("arm_tracing", VW'(tracing), VW'(1));
        send(1'b1, 1'b0, 1'b1, AW'(0));
        send(1'b0, 1'b0, 1'b1, AW'(0));
        send(1'b0, 1'b0, 1'b1, AW'(0));
        send(1'b0, 1'b0, 1'b1, AW'(0));
        send(1'b1, 1'b0, 1'b1, AW'(1));
        idle();
        tick();
        tick();
        chk("seq_last_addr", VW'(last_addr), VW'(1));
        chk("seq_wrapped", VW'(wrapped), '0);
        chk("seq_sb_empty", VW'(sb.size()), '0);

`ifdef TRACE_STOP_ON_FULL_EN
        // one-shot: fifth incrementing beat would overwrite entry 0
        pulse_arm();
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 1'b1, AW'(i));
        send(1'b1, 1'b0, 1'b0, AW'(0));
        idle();
        tick();
        chk("full_done", VW'(done), VW'(1));
        chk("full_wrapped", VW'(wrapped), VW'(1));
        chk("full_last_addr", VW'(last_addr), VW'(3));
        chk("full_tracing", VW'(tracing), '0);
`else
        // circular: 0,1,2,3,0,1 with wrapped rising on the fifth write
        pulse_arm();
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 1'b1, AW'(i));
        idle();
        tick();
        chk("wrap_not_yet", VW'(wrapped), '0);
        send(1'b1, 1'b1, 1'b1, AW'(0));
        chk("wrap_on_fifth", VW'(wrapped), VW'(1));
        send(1'b1, 1'b0, 1'b1, AW'(1));
        idle();
        tick();
        chk("wrap_last_addr", VW'(last_addr), VW'(1));
        chk("wrap_still_tracing", VW'(tracing), VW'(1));
`endif
        chk("wrap_sb_empty", VW'(sb.size()), '0);

        // post-trigger count 3 with a rewrite in between
        pulse_arm();
        send(1'b0, 1'b1, 1'b1, AW'(0));
        idle();
        trigger       = 1'b1;
        post_trig_cnt = CNT_W'(3);
        tick();
        trigger       = 1'b0;
        post_trig_cnt = '0;
        send(1'b1, 1'b0, 1'b1, AW'(1));
        send(1'b0, 1'b1, 1'b1, AW'(1));
        send(1'b1, 1'b0, 1'b1, AW'(2));
        send(1'b1, 1'b1, 1'b1, AW'(3));
        chk("post_done_early", VW'(done), '0);
        chk("post_tracing_early", VW'(tracing), VW'(1));
        send(1'b1, 1'b0, 1'b0, AW'(0));
        chk("post_done", VW'(done), VW'(1));
        chk("post_tracing", VW'(tracing), '0);
        chk("post_last_addr", VW'(last_addr), VW'(3));
        idle();
        tick();
        chk("post_sb_empty", VW'(sb.size()), '0);

        // reset applied mid-POST with c_valid high
        pulse_arm();
        trigger       = 1'b1;
        post_trig_cnt = CNT_W'(5);
        tick();
        trigger = 1'b0;
        send(1'b1, 1'b0, 1'b1, AW'(0));
        #6;
        rst_n = 1'b0;
        #1;
        chk("midrst_tracing", VW'(tracing), '0);
        chk("midrst_tb_we", VW'(bus.tb_we), '0);
        chk("midrst_done", VW'(done), '0);
        chk("midrst_last_addr", VW'(last_addr), '0);
        tick();
        chk("midrst_tb_we_hold", VW'(bus.tb_we), '0);
        rst_n = 1'b1;
        idle();
        tick();
        tick();
        chk("midrst_idle_tracing", VW'(tracing), '0);

        // arm + trigger together from IDLE: trigger ignored
        arm           = 1'b1;
        trigger       = 1'b1;
        post_trig_cnt = '0;
        tick();
        arm     = 1'b0;
        trigger = 1'b0;
        chk("armtrig_tracing", VW'(tracing), VW'(1));
        send(1'b1, 1'b0, 1'b1, AW'(0));
        idle();
        tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        chk("zero_cnt_done", VW'(done), VW'(1));
        chk("zero_cnt_tracing", VW'(tracing), '0);
        send(1'b1, 1'b0, 1'b0, AW'(0));
        idle();

        // arm beats a same-cycle c_valid
        arm = 1'b1;
        send(1'b1, 1'b0, 1'b0, AW'(0));
        arm = 1'b0;
        idle();
        chk("rearm_done", VW'(done), '0);
        chk("rearm_wrapped", VW'(wrapped), '0);
        send(1'b1, 1'b0, 1'b1, AW'(0));
        idle();
        tick();
        tick();
        chk("rearm_last_addr", VW'(last_addr), '0);
        chk("final_sb_empty", VW'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
